// File: rtl/ackfifo_ctrl.sv
// Synchronous FIFO controller driving an external single-clock RAM with one write port and one read port.
// The RAM registers the read address, so popped data appears on Q exactly one cycle after the pop.
module ackfifo_ctrl #(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 32,
  parameter int AFULL_VAL = 48
) (
  input  logic                       CLK,
  input  logic                       ARST_N,
  input  logic                       WE,
  input  logic [WIDTH-1:0]           DATA,
  input  logic                       RE,
  output logic [WIDTH-1:0]           Q,
  output logic                       DVLD,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       AFULL,
  output logic [$clog2(DEPTH):0]     WCNT,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW,
  output logic [$clog2(DEPTH)-1:0]   RAM_C_ADDR,
  output logic [WIDTH-1:0]           RAM_C_DIN,
  output logic                       RAM_C_WEN,
  output logic                       RAM_C_BLK,
  output logic [$clog2(DEPTH)-1:0]   RAM_A_ADDR,
  output logic                       RAM_A_ADDR_EN,
  output logic                       RAM_A_BLK,
  input  logic [WIDTH-1:0]           RAM_A_DOUT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AFULL = (AW+1)'(AFULL_VAL);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   wcnt;
  logic          push;
  logic          pop;

  // Handshake: a push is taken when WE=1 and FULL=0, a pop when RE=1 and EMPTY=0,
  // both in the same cycle the request is seen; a rejected request has no side effect
  // other than the OVERFLOW/UNDERFLOW pulse on the following cycle.
  assign push = WE && !FULL;
  assign pop  = RE && !EMPTY;

  assign EMPTY = (wcnt == '0);
  assign FULL  = (wcnt == CNT_FULL);
  assign AFULL = (wcnt >= CNT_AFULL);
  assign WCNT  = wcnt;

  assign RAM_C_ADDR    = wptr;
  assign RAM_C_DIN     = DATA;
  assign RAM_C_WEN     = push;
  assign RAM_C_BLK     = push;
  assign RAM_A_ADDR    = rptr;
  assign RAM_A_ADDR_EN = pop;
  assign RAM_A_BLK     = pop;

  // RAM output is already aligned with DVLD, so no local data register.
  assign Q = RAM_A_DOUT;

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      wptr      <= '0;
      rptr      <= '0;
      wcnt      <= '0;
      DVLD      <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   wcnt <= wcnt + 1'b1;
        2'b01:   wcnt <= wcnt - 1'b1;
        default: wcnt <= wcnt;
      endcase
      DVLD      <= pop;
      OVERFLOW  <= WE && FULL;
      UNDERFLOW <= RE && EMPTY;
    end
  end

endmodule

// File: tb/tb_ackfifo_ctrl.sv
// Bench for ackfifo_ctrl: behavioural RAM, queue-based reference model, directed and random traffic.
module tb_ackfifo_ctrl;

  localparam int DEPTH = 64;
  localparam int WIDTH = 32;
  localparam int AFULL_VAL = 48;
  localparam int AW = $clog2(DEPTH);

  logic             CLK;
  logic             ARST_N;
  logic             WE;
  logic [WIDTH-1:0] DATA;
  logic             RE;
  logic [WIDTH-1:0] Q;
  logic             DVLD;
  logic             FULL;
  logic             EMPTY;
  logic             AFULL;
  logic [AW:0]      WCNT;
  logic             OVERFLOW;
  logic             UNDERFLOW;
  logic [AW-1:0]    RAM_C_ADDR;
  logic [WIDTH-1:0] RAM_C_DIN;
  logic             RAM_C_WEN;
  logic             RAM_C_BLK;
  logic [AW-1:0]    RAM_A_ADDR;
  logic             RAM_A_ADDR_EN;
  logic             RAM_A_BLK;
  logic [WIDTH-1:0] RAM_A_DOUT;

  ackfifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_VAL(AFULL_VAL)) dut (
    .CLK(CLK), .ARST_N(ARST_N), .WE(WE), .DATA(DATA), .RE(RE), .Q(Q), .DVLD(DVLD),
    .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .WCNT(WCNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .RAM_C_ADDR(RAM_C_ADDR), .RAM_C_DIN(RAM_C_DIN), .RAM_C_WEN(RAM_C_WEN), .RAM_C_BLK(RAM_C_BLK),
    .RAM_A_ADDR(RAM_A_ADDR), .RAM_A_ADDR_EN(RAM_A_ADDR_EN), .RAM_A_BLK(RAM_A_BLK),
    .RAM_A_DOUT(RAM_A_DOUT)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural USRAM: registered read address, unregistered data out
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    a_q;
  always @(posedge CLK) begin
    if (RAM_C_WEN && RAM_C_BLK) mem[RAM_C_ADDR] <= RAM_C_DIN;
    if (RAM_A_ADDR_EN && RAM_A_BLK) a_q <= RAM_A_ADDR;
  end
  assign RAM_A_DOUT = mem[a_q];

  // Scoreboard state
  logic [WIDTH-1:0] exp_q[$];
  int total  = 0;
  int passed = 0;
  int wr_idx = 0;
  int rd_idx = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock cycle of traffic; called at posedge+1, returns at posedge+1
  task automatic step(input logic we, input logic [WIDTH-1:0] d, input logic re);
    bit push_ok;
    bit pop_ok;
    logic [WIDTH-1:0] word;
    word = '0;
    WE = we; DATA = d; RE = re;
    push_ok = we && (exp_q.size() < DEPTH);
    pop_ok  = re && (exp_q.size() > 0);
    #4;
    chk("ram_c_wen", 64'(RAM_C_WEN), 64'(push_ok));
    chk("ram_a_addr_en", 64'(RAM_A_ADDR_EN), 64'(pop_ok));
    if (push_ok) begin
      chk("ram_c_addr", 64'(RAM_C_ADDR), 64'(wr_idx % DEPTH));
      chk("ram_c_din", 64'(RAM_C_DIN), 64'(d));
    end
    if (pop_ok) chk("ram_a_addr", 64'(RAM_A_ADDR), 64'(rd_idx % DEPTH));
    @(posedge CLK);
    #1;
    if (pop_ok) begin
      word = exp_q.pop_front();
      rd_idx++;
    end
    if (push_ok) begin
      exp_q.push_back(d);
      wr_idx++;
    end
    chk("dvld", 64'(DVLD), 64'(pop_ok));
    if (pop_ok) chk("q", 64'(Q), 64'(word));
    chk("wcnt", 64'(WCNT), 64'(exp_q.size()));
    chk("full", 64'(FULL), 64'(exp_q.size() == DEPTH));
    chk("empty", 64'(EMPTY), 64'(exp_q.size() == 0));
    chk("afull", 64'(AFULL), 64'(exp_q.size() >= AFULL_VAL));
    chk("overflow", 64'(OVERFLOW), 64'(we && !push_ok));
    chk("underflow", 64'(UNDERFLOW), 64'(re && !pop_ok));
    WE = 1'b0; RE = 1'b0;
  endtask

  initial begin
    WE = 1'b0; RE = 1'b0; DATA = '0;
    ARST_N = 1'b1;
    #1 ARST_N = 1'b0;
    #2;
    chk("rst_wcnt", 64'(WCNT), 64'd0);
    chk("rst_empty", 64'(EMPTY), 64'd1);
    chk("rst_full", 64'(FULL), 64'd0);
    chk("rst_afull", 64'(AFULL), 64'd0);
    chk("rst_dvld", 64'(DVLD), 64'd0);
    chk("rst_ovf", 64'(OVERFLOW), 64'd0);
    chk("rst_unf", 64'(UNDERFLOW), 64'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1 ARST_N = 1'b1;

    // Fill with 1..64, AFULL rising at 48
    for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
    chk("fill_wcnt", 64'(WCNT), 64'(DEPTH));
    // Push into full FIFO
    step(1'b1, 32'hDEADBEEF, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("ovf_cleared", 64'(OVERFLOW), 64'd0);
    // Drain in order, then pop while empty
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    // WE=RE at empty
    step(1'b1, 32'hA5A5_0001, 1'b1);
    chk("sim_empty_wcnt", 64'(WCNT), 64'd1);
    // Raise occupancy to 5 and stream 130 words through two wraps
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_1000 + 32'(i), 1'b0);
    for (int i = 0; i < 130; i++) begin
      step(1'b1, 32'h0000_2000 + 32'(i), 1'b1);
      chk("stream_wcnt5", 64'(WCNT), 64'd5);
    end
    // Fill up, then WE=RE at full
    while (exp_q.size() < DEPTH) step(1'b1, $urandom, 1'b0);
    step(1'b1, 32'hCAFE_F00D, 1'b1);
    chk("sim_full_wcnt", 64'(WCNT), 64'(DEPTH - 1));

    // Random traffic, biased toward draining then filling
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0));
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

    // Reset between pop edge and DVLD cycle with 10 entries stored
    while (exp_q.size() > 10) step(1'b0, '0, 1'b1);
    while (exp_q.size() < 10) step(1'b1, $urandom, 1'b0);
    chk("pre_rst_wcnt", 64'(WCNT), 64'd10);
    RE = 1'b1;
    @(posedge CLK);
    #1 ARST_N = 1'b0;
    RE = 1'b0;
    #1;
    chk("midrst_dvld", 64'(DVLD), 64'd0);
    chk("midrst_wcnt", 64'(WCNT), 64'd0);
    chk("midrst_empty", 64'(EMPTY), 64'd1);
    exp_q.delete();
    wr_idx = 0;
    rd_idx = 0;
    #2 ARST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_rst_dvld", 64'(DVLD), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ackfifo_ctrl.md
ACKFIFO_CTRL -- requirements
Module: ackfifo_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning number of RAM entries (power of two).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning data word width.
REQ-003 The block SHALL have parameter AFULL_VAL, default 48, meaning occupancy at or above which AFULL asserts.
REQ-004 The block SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port ARST_N  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port WE  input  1  push request.
REQ-007 The block SHALL have port DATA  input  WIDTH  push data.
REQ-008 The block SHALL have port RE  input  1  pop request.
REQ-009 The block SHALL have port Q  output  WIDTH  popped data, valid when DVLD=1.
REQ-010 The block SHALL have port DVLD  output  1  Q valid strobe.
REQ-011 The block SHALL have ports FULL, EMPTY, AFULL  output  1 each  status flags.
REQ-012 The block SHALL have port WCNT  output  log2(DEPTH)+1  occupancy, 0..DEPTH.
REQ-013 The block SHALL have ports OVERFLOW, UNDERFLOW  output  1 each  one-cycle error pulses.
REQ-014 The block SHALL have ports RAM_C_ADDR out log2(DEPTH), RAM_C_DIN out WIDTH, RAM_C_WEN out 1, RAM_C_BLK out 1  write port to the 64x32 USRAM.
REQ-015 The block SHALL have ports RAM_A_ADDR out log2(DEPTH), RAM_A_ADDR_EN out 1, RAM_A_BLK out 1, RAM_A_DOUT in WIDTH  read port to the USRAM (address registered in RAM, output not registered).

Function
REQ-016 Push accepted when WE=1 and FULL=0; in that cycle RAM_C_WEN=1, RAM_C_BLK=1, RAM_C_ADDR=wptr, RAM_C_DIN=DATA (combinational); wptr increments at the edge.
REQ-017 Pop accepted when RE=1 and EMPTY=0; in that cycle RAM_A_ADDR=rptr, RAM_A_ADDR_EN=1, RAM_A_BLK=1; rptr increments at the edge.
REQ-018 Read latency SHALL be exactly 1 cycle: DVLD=1 in the cycle after an accepted pop, Q=RAM_A_DOUT (no extra register).
REQ-019 When no pop is accepted, RAM_A_ADDR_EN=0 so Q holds the last popped word; DVLD=0.
REQ-020 Pointers SHALL wrap DEPTH-1 -> 0 without gaps.
REQ-021 WCNT SHALL be registered: +1 on push-only, -1 on pop-only, unchanged on simultaneous accepted push and pop or on neither.
REQ-022 EMPTY = (WCNT==0), FULL = (WCNT==DEPTH), AFULL = (WCNT>=AFULL_VAL), all decoded from registered state.
REQ-023 Simultaneous WE and RE while FULL: pop accepted, push rejected, OVERFLOW pulses next cycle, WCNT becomes DEPTH-1.
REQ-024 Simultaneous WE and RE while EMPTY: push accepted, pop rejected, UNDERFLOW pulses next cycle, WCNT becomes 1; no same-cycle read of the word being written.
REQ-025 WE with FULL=1 (and no pop) SHALL assert OVERFLOW for one cycle after; RE with EMPTY=1 SHALL assert UNDERFLOW for one cycle after; state unchanged.
REQ-026 RAM_C_WEN, RAM_A_ADDR_EN SHALL be 0 whenever the corresponding request is rejected.

Reset
REQ-027 ARST_N=0 SHALL immediately clear wptr, rptr, WCNT to 0, DVLD, OVERFLOW, UNDERFLOW, FULL, AFULL to 0, EMPTY to 1, independent of CLK.
REQ-028 Reset SHALL NOT clear RAM contents; Q is undefined until first DVLD after reset.
REQ-029 Reset asserted mid-operation SHALL discard a pop in flight (no DVLD after release) and all stored entries.
REQ-030 Release of ARST_N SHALL take effect at the next rising CLK edge; first push accepted in that cycle.

Verification
REQ-031 Push 0x00000001..0x00000040 (64 words) -> FULL=1 after 64th edge, WCNT=64, AFULL rose when WCNT reached 48.
REQ-032 From full, push 0xDEADBEEF -> OVERFLOW one-cycle pulse, WCNT stays 64, no RAM_C_WEN.
REQ-033 Pop 64 words -> DVLD each next cycle, Q=0x00000001..0x00000040 in order, EMPTY=1 after last; further RE -> UNDERFLOW pulse.
REQ-034 Push/pop continuously across 130 words with WCNT held at 5 -> data order preserved across two pointer wraps, WCNT constant 5.
REQ-035 WE=RE=1 at EMPTY and at FULL -> REQ-024 and REQ-023 outcomes exactly.
REQ-036 Assert ARST_N=0 between pop request edge and DVLD cycle with WCNT=10 -> DVLD=0, WCNT=0, EMPTY=1 asynchronously.
